// File: rtl/fifo_pkg.sv
// Shared defaults for the FIFO controller: data width, depth, address width
// and the almost-full / almost-empty thresholds.
package fifo_pkg;

    localparam int FIFO_WIDTH    = 8;
    localparam int FIFO_DEPTH    = 16;
    localparam int FIFO_ADDR     = 4;
    localparam int FIFO_AF_LEVEL = 14;
    localparam int FIFO_AE_LEVEL = 2;

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// Wrapping W-bit pointer with enable and asynchronous reset; the MSB is the
// lap bit that separates full from empty when the address bits match.
module fifo_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    assign ptr_d = ptr_q + {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (en_i) begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule : fifo_ptr

// File: rtl/fifo_ctrl_16.sv
// FIFO controller for an external 16x8 synchronous RAM: gates push/pop into
// RAM enables, tracks occupancy and keeps sticky overflow/underflow flags.
module fifo_ctrl_16
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_WIDTH,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int ADDR     = FIFO_ADDR,
    parameter int AF_LEVEL = FIFO_AF_LEVEL,
    parameter int AE_LEVEL = FIFO_AE_LEVEL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_err,
    output logic             We,
    output logic             Re,
    output logic [ADDR-1:0]  Wr_addr,
    output logic [ADDR-1:0]  Rd_addr,
    output logic [WIDTH-1:0] data_in,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow,
    output logic [ADDR:0]    count
);

    // A threshold above capacity could never be reached, so clamp it.
    localparam int            AF_CLAMP = (AF_LEVEL > DEPTH) ? DEPTH : AF_LEVEL;
    localparam logic [ADDR:0] AF_THR   = AF_CLAMP[ADDR:0];
    localparam logic [ADDR:0] AE_THR   = AE_LEVEL[ADDR:0];

    logic [ADDR:0] wr_ptr;
    logic [ADDR:0] rd_ptr;
    logic          we_acc;
    logic          re_acc;

    logic rd_valid_q, rd_valid_d;
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // Full blocks the push and empty blocks the pop, so a read never hits
    // the slot being written in the same cycle.
    assign we_acc = push & ~full;
    assign re_acc = pop & ~empty;

    fifo_ptr #(.W(ADDR + 1)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (we_acc),
        .ptr_o (wr_ptr)
    );

    fifo_ptr #(.W(ADDR + 1)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (re_acc),
        .ptr_o (rd_ptr)
    );

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR-1:0] == rd_ptr[ADDR-1:0]) &&
                   (wr_ptr[ADDR] != rd_ptr[ADDR]);
    assign count = wr_ptr - rd_ptr;

    assign almost_full  = (count >= AF_THR);
    assign almost_empty = (count <= AE_THR);

    assign We      = we_acc;
    assign Re      = re_acc;
    assign Wr_addr = wr_ptr[ADDR-1:0];
    assign Rd_addr = rd_ptr[ADDR-1:0];
    assign data_in = wr_data;

    // A new error in the same cycle as clr_err keeps the flag set.
    always_comb begin
        rd_valid_d = re_acc;
        ovf_d      = (ovf_q & ~clr_err) | (push & full);
        unf_d      = (unf_q & ~clr_err) | (pop & empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule : fifo_ctrl_16

// File: tb/tb_fifo_ctrl_16.sv
// Bench for fifo_ctrl_16: queue-based reference model, a bench-side RAM and
// a read-data scoreboard checked by an independent monitor.
module tb_fifo_ctrl_16;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic       pop;
    logic [7:0] wr_data;
    logic       clr_err;
    logic       We;
    logic       Re;
    logic [3:0] Wr_addr;
    logic [3:0] Rd_addr;
    logic [7:0] data_in;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;
    logic [4:0] count;

    fifo_ctrl_16 dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .wr_data      (wr_data),
        .clr_err      (clr_err),
        .We           (We),
        .Re           (Re),
        .Wr_addr      (Wr_addr),
        .Rd_addr      (Rd_addr),
        .data_in      (data_in),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .count        (count)
    );

    always #5 clk = ~clk;

    // Synchronous RAM the controller drives; no reset, contents survive rst.
    logic [7:0] ram [16];
    logic [7:0] ram_dout;
    always @(posedge clk) begin
        if (We) ram[Wr_addr] <= data_in;
        if (Re) ram_dout <= ram[Rd_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: stored data, data expected on the read port,
    // accepted transaction totals and sticky error flags.
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int         wr_n, rd_n;
    bit         m_ovf, m_unf, m_prev_re;

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", {24'd0, ram_dout}, {24'd0, e});
            end
        end
    end

    task automatic step(input bit p, input bit q, input logic [7:0] d, input bit c);
        bit fl, em, ew, er;
        push = p; pop = q; wr_data = d; clr_err = c;
        @(negedge clk);
        fl = (mq.size() == 16);
        em = (mq.size() == 0);
        ew = p && !fl;
        er = q && !em;
        chk("We", {31'd0, We}, {31'd0, ew});
        chk("Re", {31'd0, Re}, {31'd0, er});
        chk("count", {27'd0, count}, mq.size());
        chk("full", {31'd0, full}, {31'd0, fl});
        chk("empty", {31'd0, empty}, {31'd0, em});
        chk("almost_full", {31'd0, almost_full}, (mq.size() >= 14) ? 1 : 0);
        chk("almost_empty", {31'd0, almost_empty}, (mq.size() <= 2) ? 1 : 0);
        chk("Wr_addr", {28'd0, Wr_addr}, wr_n % 16);
        chk("Rd_addr", {28'd0, Rd_addr}, rd_n % 16);
        chk("data_in", {24'd0, data_in}, {24'd0, d});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("underflow", {31'd0, underflow}, {31'd0, m_unf});
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_prev_re});
        if (er) begin
            exp_q.push_back(mq.pop_front());
            rd_n++;
        end
        if (ew) begin
            mq.push_back(d);
            wr_n++;
        end
        m_ovf     = (m_ovf && !c) || (p && fl);
        m_unf     = (m_unf && !c) || (q && em);
        m_prev_re = er;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        #1;
        chk("rst_count", {27'd0, count}, 0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 0);
        chk("rst_empty", {31'd0, empty}, 1);
        chk("rst_almost_empty", {31'd0, almost_empty}, 1);
        chk("rst_full", {31'd0, full}, 0);
        chk("rst_almost_full", {31'd0, almost_full}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_underflow", {31'd0, underflow}, 0);
        chk("rst_Wr_addr", {28'd0, Wr_addr}, 0);
        chk("rst_Rd_addr", {28'd0, Rd_addr}, 0);
        mq.delete();
        exp_q.delete();
        wr_n = 0; rd_n = 0;
        m_ovf = 0; m_unf = 0; m_prev_re = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
        #2;
        do_reset();

        // Idle after reset.
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // Fill with 0x10..0x1F, then one push too many.
        for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h10 + i), 0);
        step(1, 0, 8'hEE, 0);
        // Push+pop while full: only the pop is taken, overflow still set.
        step(1, 1, 8'hEF, 0);
        step(1, 0, 8'h20, 0);

        // Drain everything, then pop once more while empty.
        for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // Five stored, then steady push+pop across several address wraps.
        for (int i = 0; i < 5; i++) step(1, 0, 8'($urandom), 0);
        for (int i = 0; i < 40; i++) step(1, 1, 8'($urandom), 0);
        for (int i = 0; i < 5; i++) step(0, 1, 8'h00, 0);

        // Empty with push+pop: only the push is taken, underflow set,
        // and a clear coinciding with a new error keeps the flag.
        step(1, 1, 8'hA5, 0);
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // Randomized traffic, push-heavy then pop-heavy.
        for (int i = 0; i < 400; i++) begin
            bit p, q, c;
            p = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            q = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 15) == 0);
            step(p, q, 8'($urandom), c);
        end

        // Reset with seven entries stored and a read in flight.
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h40 + i), 0);
        step(0, 1, 8'h00, 0);
        chk("rd_valid_inflight", {31'd0, rd_valid}, 1);
        do_reset();
        step(0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h70 + i), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0);

        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fifo_ctrl_16

// File: doc/fifo_ctrl_16.md
FIFO_CTRL_16 -- requirements
Module: fifo_ctrl_16

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the data width in bits.
REQ-002 The block SHALL take parameter DEPTH, default 16, as the number of RAM entries.
REQ-003 The block SHALL take parameter ADDR, default 4, as the RAM address width.
REQ-004 The block SHALL take parameter AF_LEVEL, default 14, as the almost_full threshold.
REQ-005 The block SHALL take parameter AE_LEVEL, default 2, as the almost_empty threshold.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port push, input, 1 bit: write request.
REQ-009 The block SHALL have port pop, input, 1 bit: read request.
REQ-010 The block SHALL have port wr_data, input, WIDTH bits: data to store.
REQ-011 The block SHALL have port clr_err, input, 1 bit: clears the sticky error flags.
REQ-012 The block SHALL have port We, output, 1 bit: RAM write enable.
REQ-013 The block SHALL have port Re, output, 1 bit: RAM read enable.
REQ-014 The block SHALL have port Wr_addr, output, ADDR bits: RAM write address.
REQ-015 The block SHALL have port Rd_addr, output, ADDR bits: RAM read address.
REQ-016 The block SHALL have port data_in, output, WIDTH bits: RAM write data.
REQ-017 The block SHALL have outputs rd_valid, full, empty, almost_full, almost_empty, overflow and underflow, each 1 bit, and count, ADDR+1 bits.

Function
REQ-018 The block SHALL accept a push (We=1) exactly when push=1 and full=0, and a pop (Re=1) exactly when pop=1 and empty=0; We and Re are combinational in the same cycle.
REQ-019 The block SHALL drive Wr_addr and Rd_addr from the low ADDR bits of the registered ADDR+1-bit write and read pointers, and SHALL pass data_in straight through from wr_data.
REQ-020 On each accepted push or pop, the corresponding pointer SHALL increment at the clock edge, wrapping from 31 to 0; the MSB acts as the lap bit.
REQ-021 empty SHALL be 1 when the pointers are equal, and full SHALL be 1 when the low bits are equal and the MSBs differ.
REQ-022 count SHALL equal wr_ptr minus rd_ptr modulo 32, with range 0..16.
REQ-023 almost_full SHALL be 1 when count >= AF_LEVEL, and almost_empty SHALL be 1 when count <= AE_LEVEL.
REQ-024 rd_valid SHALL be Re registered by one cycle, so it coincides with valid RAM data_out (one-cycle read latency).
REQ-025 Simultaneous accepted push and pop SHALL advance both pointers and leave count unchanged.
REQ-026 When full=1, push+pop SHALL accept only the pop; when empty=1, push+pop SHALL accept only the push, so Re=1 never occurs on a slot being written the same cycle.
REQ-027 overflow SHALL be set on push while full, and underflow SHALL be set on pop while empty; both are sticky until clr_err=1.
REQ-028 If clr_err=1 coincides with a new error, the set SHALL win.

Reset
REQ-029 While rst=1, independent of clk, the pointers, count, rd_valid, overflow and underflow SHALL be 0, empty and almost_empty SHALL be 1, and full and almost_full SHALL be 0.
REQ-030 A reset mid-operation SHALL discard in-flight reads (rd_valid=0) and SHALL NOT clear RAM contents.
REQ-031 The pointers SHALL restart at address 0 after reset.

Structure
REQ-032 WIDTH, DEPTH, ADDR, AF_LEVEL and AE_LEVEL defaults SHALL live in shared package fifo_pkg.
REQ-033 The block SHALL instantiate sub-module fifo_ptr (an ADDR+1-bit wrapping counter with enable and async reset) twice, once for the write pointer and once for the read pointer.
REQ-034 The block SHALL contain no storage array; it drives the 16x8 synchronous RAM directly.

Verification
REQ-035 Reset then idle -> empty=1, count=0, We=0, Re=0, Wr_addr=0, Rd_addr=0.
REQ-036 Push 16 values 0x10..0x1F -> count reaches 16, full=1, almost_full=1 from count 14; a 17th push leaves We=0 and sets overflow=1.
REQ-037 Pop all 16 after the fill -> rd_valid pulses one cycle after each Re, data_out is 0x10..0x1F in order, and empty=1 at the end.
REQ-038 With 5 entries stored, hold push+pop for 40 cycles -> count stays 5, addresses wrap 15->0 and the pointer MSBs toggle, with no data loss.
REQ-039 Empty with push+pop in the same cycle -> only We=1, underflow=1, count=1; pulsing clr_err then gives underflow=0.
REQ-040 Assert rst with 7 entries stored and a pop in flight -> count=0, rd_valid=0, empty=1 immediately, without waiting for a clock edge.
